// File: rtl/fft_pkg.sv
// Shared definitions for the 64-point SDF FFT and its frame sequencer.
//   N, LOG2N     : frame size and index width
//   FFT_LATENCY  : cycles from first data_in_en to first valid output sample
//   frame_state_e: frame sequencer states
//   bitrev()     : maps output order k to natural frequency bin
package fft_pkg;

    localparam int unsigned N           = 64;
    localparam int unsigned LOG2N       = 6;
    localparam int unsigned FFT_LATENCY = 71;

    typedef enum logic [1:0] {
        StIdle,
        StBurst,
        StWait,
        StOut
    } frame_state_e;

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] x);
        logic [LOG2N-1:0] r;
        for (int i = 0; i < LOG2N; i++) begin
            r[i] = x[LOG2N-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_frame_buf.sv
// Frame buffer: DEPTH x DATA_W RAM, one write port, one synchronous read port.
//   clock, reset      : system clock, sync active-low reset (read register only)
//   wr_en/addr/data   : write port
//   rd_en/addr        : read request; rd_data updates on the following edge
//   rd_data           : registered read data, holds when rd_en is low
module fft_frame_buf #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned ADDR_W = 6
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Contents are not reset; only the read register is, so outputs are zero after reset.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/fft_frame_ctrl.sv
// Frame sequencer for the 64-point SDF FFT.
// Fills a frame buffer from a bursty valid/ready producer, replays each full frame to the
// FFT as one gap-free N-cycle burst, then qualifies the FFT output stream.
//   clock, reset                 : system clock, sync active-low reset (shared with FFT)
//   in_valid/in_ready/in_real/in_imag : producer interface
//   fft_in_en/fft_in_real/fft_in_imag : FFT input drive, registered
//   out_valid/out_index/out_last : FFT output qualifiers (index is the natural bin)
//   busy                         : a frame is bursting, in the pipeline or being output
//   frame_count                  : frames fully output, wraps at 2^16
module fft_frame_ctrl #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned N       = fft_pkg::N,
    parameter int unsigned LOG2N   = fft_pkg::LOG2N,
    parameter int unsigned LATENCY = fft_pkg::FFT_LATENCY
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_real,
    input  logic [WIDTH-1:0] in_imag,
    output logic             fft_in_en,
    output logic [WIDTH-1:0] fft_in_real,
    output logic [WIDTH-1:0] fft_in_imag,
    output logic             out_valid,
    output logic [LOG2N-1:0] out_index,
    output logic             out_last,
    output logic             busy,
    output logic [15:0]      frame_count
);

    import fft_pkg::*;

    // WAIT covers the gap between the end of the burst and the first output sample; the
    // burst itself already accounts for N-1 cycles of the latency after the first fft_in_en.
    localparam int unsigned      WaitCycles = LATENCY - N + 1;
    localparam logic [LOG2N-1:0] LastIdx    = LOG2N'(N - 1);
    localparam logic [LOG2N-1:0] LastWait   = LOG2N'(WaitCycles - 1);

    frame_state_e     state_q, state_d;
    logic [LOG2N-1:0] cnt_q, cnt_d;
    logic [LOG2N-1:0] wr_cnt_q;
    logic             full_q, full_d;
    logic             accept, rd_en, rd_last;

    assign accept  = in_valid && in_ready;
    assign rd_en   = (state_q == StBurst);
    assign rd_last = rd_en && (cnt_q == LastIdx);

    // Input side runs independently of the FSM so the next frame can fill during WAIT/OUT.
    always_comb begin
        full_d = full_q;
        if (rd_last) begin
            full_d = 1'b0;
        end
        if (accept && (wr_cnt_q == LastIdx)) begin
            full_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            full_q   <= 1'b0;
            wr_cnt_q <= '0;
            in_ready <= 1'b0;
        end else begin
            full_q   <= full_d;
            in_ready <= !full_d;
            if (accept) begin
                wr_cnt_q <= wr_cnt_q + 1'b1;
            end
        end
    end

    fft_frame_buf #(
        .DATA_W (2 * WIDTH),
        .DEPTH  (N),
        .ADDR_W (LOG2N)
    ) u_buf (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (accept),
        .wr_addr (wr_cnt_q),
        .wr_data ({in_real, in_imag}),
        .rd_en   (rd_en),
        .rd_addr (cnt_q),
        .rd_data ({fft_in_real, fft_in_imag})
    );

    // One counter serves as read index in BURST, latency timer in WAIT and bin order k in OUT.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (full_q) begin
                    state_d = StBurst;
                end
            end
            StBurst: begin
                if (cnt_q == LastIdx) begin
                    state_d = StWait;
                    cnt_d   = '0;
                end
            end
            StWait: begin
                if (cnt_q == LastWait) begin
                    state_d = StOut;
                    cnt_d   = '0;
                end
            end
            StOut: begin
                if (cnt_q == LastIdx) begin
                    state_d = full_q ? StBurst : StIdle;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            fft_in_en   <= 1'b0;
            frame_count <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            // Aligned with the registered read data.
            fft_in_en <= rd_en;
            if (out_last) begin
                frame_count <= frame_count + 16'd1;
            end
        end
    end

    assign out_valid = (state_q == StOut);
    assign out_index = out_valid ? bitrev(cnt_q) : '0;
    assign out_last  = out_valid && (cnt_q == LastIdx);
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_fft_frame_ctrl.sv
module tb_fft_frame_ctrl;

    localparam int W   = 16;
    localparam int N   = 64;
    localparam int LAT = 71;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_real = '0;
    logic [W-1:0]  in_imag = '0;
    logic          fft_in_en;
    logic [W-1:0]  fft_in_real;
    logic [W-1:0]  fft_in_imag;
    logic          out_valid;
    logic [5:0]    out_index;
    logic          out_last;
    logic          busy;
    logic [15:0]   frame_count;

    fft_frame_ctrl dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_real     (in_real),
        .in_imag     (in_imag),
        .fft_in_en   (fft_in_en),
        .fft_in_real (fft_in_real),
        .fft_in_imag (fft_in_imag),
        .out_valid   (out_valid),
        .out_index   (out_index),
        .out_last    (out_last),
        .busy        (busy),
        .frame_count (frame_count)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] exp_q[$];      // accepted samples awaiting their burst slot
    int          out_start_q[$]; // cycle at which each frame's first output is due
    int  fill = 0, en_run = 0, out_k = 0, frames_done = 0;
    bit  waiting_full = 0, out_active = 0, mon_on = 0, b2b_on = 0, seq_data = 0;
    int  last_cyc = -1, send_left = 0, duty = 100, seq_k = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int rev(input int k);
        int r = 0;
        int v = k;
        for (int i = 0; i < 6; i++) begin
            r = r * 2 + (v % 2);
            v = v / 2;
        end
        return r;
    endfunction

    task automatic observe();
        logic [31:0] d;
        chk("frame_count", frame_count, frames_done);
        if (fft_in_en === 1'b1) begin
            if (exp_q.size() == 0) chk("burst_extra", fft_in_en, 0);
            else begin
                d = exp_q.pop_front();
                chk("burst_data", {fft_in_real, fft_in_imag}, d);
            end
            en_run++;
            if (en_run == 1) begin
                out_start_q.push_back(cyc + LAT);
                if (b2b_on && last_cyc >= 0) chk("b2b_gap", cyc - last_cyc, 2);
            end
            if (en_run == N) begin
                en_run = 0;
                waiting_full = 0;
            end
        end else if (en_run != 0) begin
            chk("burst_gap", fft_in_en, 1);
            en_run = 0;
        end
        chk("in_ready", in_ready, !waiting_full);
        if (!out_active && out_start_q.size() > 0 && out_start_q[0] == cyc) begin
            void'(out_start_q.pop_front());
            out_active = 1;
        end
        if (out_active) begin
            chk("out_valid", out_valid, 1);
            chk("out_index", out_index, rev(out_k));
            chk("out_last", out_last, out_k == N - 1);
            chk("busy_out", busy, 1);
            out_k++;
            if (out_k == N) begin
                out_k = 0;
                out_active = 0;
                frames_done++;
                last_cyc = cyc;
            end
        end else begin
            chk("out_valid_idle", out_valid, 0);
        end
    endtask

    task automatic drive();
        if (send_left > 0 && $urandom_range(99) < duty) begin
            in_valid = 1'b1;
            if (seq_data) begin
                in_real = W'(seq_k);
                in_imag = W'(-seq_k);
            end else begin
                {in_real, in_imag} = $urandom;
            end
            if (in_ready === 1'b1) begin
                exp_q.push_back({in_real, in_imag});
                send_left--;
                seq_k++;
                fill++;
                if (fill == N) begin
                    fill = 0;
                    waiting_full = 1;
                end
            end
        end else begin
            in_valid = 1'b0;
        end
    endtask

    task automatic step();
        @(negedge clock);
        if (mon_on) observe();
        drive();
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        in_valid = 1'b0;
        @(negedge clock);
        chk("rst_fft_in_en", fft_in_en, 0);
        chk("rst_fft_in_data", {fft_in_real, fft_in_imag}, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_index", out_index, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_count", frame_count, 0);
        chk("rst_in_ready", in_ready, 0);
        exp_q.delete();
        out_start_q.delete();
        fill = 0; en_run = 0; out_k = 0; frames_done = 0;
        waiting_full = 0; out_active = 0; send_left = 0; last_cyc = -1;
        reset = 1'b1;
        @(negedge clock);
        chk("rel_in_ready", in_ready, 1);
        chk("rel_busy", busy, 0);
        chk("rel_out_valid", out_valid, 0);
    endtask

    task automatic run_frames(input int target, input int budget);
        int n = 0;
        while (frames_done < target && n < budget) begin
            step();
            n++;
        end
        step();
        chk("frames_end", frame_count, target);
    endtask

    initial begin
        apply_reset();
        mon_on = 1;

        // Contiguous fill, re=k, im=-k
        seq_data = 1; seq_k = 0; duty = 100; send_left = N;
        run_frames(1, 600);
        step();
        chk("idle_busy", busy, 0);

        // Random gaps, random data
        seq_data = 0; duty = 50; send_left = N;
        run_frames(2, 900);

        // Back-to-back frames; producer keeps in_valid high through the burst
        duty = 100; send_left = 2 * N; b2b_on = 1; last_cyc = -1;
        run_frames(4, 1200);
        b2b_on = 0;

        // Reset mid-burst at read index 20
        send_left = N;
        for (int n = 0; n < 400 && en_run != 20; n++) step();
        chk("trig_burst", en_run, 20);
        apply_reset();
        for (int n = 0; n < 200; n++) step();
        chk("abort_frames", frame_count, 0);

        // Reset during output at k=10
        send_left = N; duty = 100;
        for (int n = 0; n < 400 && out_k != 11; n++) step();
        chk("trig_out", out_k, 11);
        apply_reset();
        for (int n = 0; n < 100; n++) step();

        // Recovery frame after abort
        duty = 70; send_left = N;
        run_frames(1, 900);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
